// File: rtl/branch_history_table.sv
// Branch history table: 2-bit saturating counters indexed by PC bits.
// Predicts in ID, trains and flags mispredictions in EX, and keeps
// saturating counts of resolved and mispredicted branches.
module branch_history_table #(
  parameter int ENTRIES = 16,
  parameter int IDX_LSB = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lookup_valid_i,
  input  logic [31:0] lookup_pc_i,
  output logic        predict_o,
  input  logic        resolve_valid_i,
  input  logic [31:0] resolve_pc_i,
  input  logic        resolve_predict_i,
  input  logic        resolve_taken_i,
  output logic        flush_o,
  output logic        redirect_taken_o,
  output logic [15:0] branch_count_o,
  output logic [15:0] mispredict_count_o
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  logic [1:0]       counters [ENTRIES];
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] resolve_idx;
  logic [1:0]       resolve_ctr;
  logic             mispredict;
  logic [15:0]      branch_count;
  logic [15:0]      mispredict_count;
  logic             unused_pc_bits;

  assign lookup_idx  = lookup_pc_i[IDX_LSB +: IDX_W];
  assign resolve_idx = resolve_pc_i[IDX_LSB +: IDX_W];
  assign resolve_ctr = counters[resolve_idx];
  assign mispredict  = resolve_valid_i & (resolve_predict_i != resolve_taken_i);

  // Only the index bits of either PC matter; the table carries no tags.
  assign unused_pc_bits = ^{lookup_pc_i, resolve_pc_i};

  // Outputs are gated by reset so nothing leaks out while rst_i is high.
  assign predict_o          = ~rst_i & lookup_valid_i & counters[lookup_idx][1];
  assign flush_o            = ~rst_i & mispredict;
  assign redirect_taken_o   = flush_o & resolve_taken_i;
  assign branch_count_o     = branch_count;
  assign mispredict_count_o = mispredict_count;

  // Train the resolved entry one step toward the actual outcome, from table state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        counters[i] <= 2'b01;
      end
    end else if (resolve_valid_i) begin
      if (resolve_taken_i) begin
        if (resolve_ctr != 2'b11) begin
          counters[resolve_idx] <= resolve_ctr + 2'b01;
        end
      end else begin
        if (resolve_ctr != 2'b00) begin
          counters[resolve_idx] <= resolve_ctr - 2'b01;
        end
      end
    end
  end

  // Saturating statistics: resolved branches and mispredictions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_count     <= 16'h0000;
      mispredict_count <= 16'h0000;
    end else begin
      if (resolve_valid_i && (branch_count != 16'hFFFF)) begin
        branch_count <= branch_count + 16'h0001;
      end
      if (mispredict && (mispredict_count != 16'hFFFF)) begin
        mispredict_count <= mispredict_count + 16'h0001;
      end
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Self-checking bench for branch_history_table (ENTRIES 16, IDX_LSB 2).
module tb_branch_history_table;

  logic        clk;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        predict;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_predict;
  logic        resolve_taken;
  logic        flush;
  logic        redirect_taken;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_history_table #(.ENTRIES(16), .IDX_LSB(2)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .lookup_valid_i     (lookup_valid),
    .lookup_pc_i        (lookup_pc),
    .predict_o          (predict),
    .resolve_valid_i    (resolve_valid),
    .resolve_pc_i       (resolve_pc),
    .resolve_predict_i  (resolve_predict),
    .resolve_taken_i    (resolve_taken),
    .flush_o            (flush),
    .redirect_taken_o   (redirect_taken),
    .branch_count_o     (branch_count),
    .mispredict_count_o (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [31:0] lpc;
    logic        rv;
    logic [31:0] rpc;
    logic        rp;
    logic        rt;
    logic        e_pred;
    logic        e_flush;
    logic        e_redir;
    logic [15:0] e_bc;
    logic [15:0] e_mc;
  } vec_t;

  typedef struct {
    int          id;
    logic        e_pred;
    logic        e_flush;
    logic        e_redir;
    logic [15:0] e_bc;
    logic [15:0] e_mc;
  } exp_t;

  vec_t vecs [26];
  exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic lv, input logic [31:0] lpc,
                              input logic rv, input logic [31:0] rpc,
                              input logic rp, input logic rt,
                              input logic ep, input logic ef, input logic er,
                              input logic [15:0] bc, input logic [15:0] mc);
    vec_t v;
    v.lv = lv; v.lpc = lpc; v.rv = rv; v.rpc = rpc; v.rp = rp; v.rt = rt;
    v.e_pred = ep; v.e_flush = ef; v.e_redir = er; v.e_bc = bc; v.e_mc = mc;
    return v;
  endfunction

  task automatic drive_idle();
    lookup_valid = 1'b0; lookup_pc = 32'h0;
    resolve_valid = 1'b0; resolve_pc = 32'h0;
    resolve_predict = 1'b0; resolve_taken = 1'b0;
  endtask

  initial begin
    exp_t e;

    // Expected values are the state before each vector's clock edge.
    // 0x40 and 0x80 share index 0; 0x44 is index 1.
    vecs[0]  = mk(1, 32'h40, 0, 32'h00, 0, 0, 0, 0, 0,  0, 0);
    vecs[1]  = mk(0, 32'h40, 1, 32'h40, 0, 1, 0, 1, 1,  0, 0);
    vecs[2]  = mk(1, 32'h40, 1, 32'h40, 1, 1, 1, 0, 0,  1, 1);
    vecs[3]  = mk(1, 32'h40, 0, 32'h00, 0, 0, 1, 0, 0,  2, 1);
    vecs[4]  = mk(1, 32'h40, 1, 32'h40, 1, 1, 1, 0, 0,  2, 1);
    vecs[5]  = mk(1, 32'h40, 1, 32'h40, 1, 1, 1, 0, 0,  3, 1);
    vecs[6]  = mk(1, 32'h40, 1, 32'h40, 1, 1, 1, 0, 0,  4, 1);
    vecs[7]  = mk(1, 32'h40, 1, 32'h40, 1, 1, 1, 0, 0,  5, 1);
    vecs[8]  = mk(1, 32'h40, 0, 32'h00, 0, 0, 1, 0, 0,  6, 1);
    vecs[9]  = mk(1, 32'h40, 1, 32'h40, 1, 0, 1, 1, 0,  6, 1);
    vecs[10] = mk(1, 32'h40, 1, 32'h40, 1, 0, 1, 1, 0,  7, 2);
    vecs[11] = mk(1, 32'h40, 0, 32'h00, 0, 0, 0, 0, 0,  8, 3);
    vecs[12] = mk(1, 32'h44, 1, 32'h80, 0, 1, 0, 1, 1,  8, 3);
    vecs[13] = mk(1, 32'h80, 1, 32'h40, 1, 1, 1, 0, 0,  9, 4);
    vecs[14] = mk(1, 32'h80, 0, 32'h00, 0, 0, 1, 0, 0, 10, 4);
    vecs[15] = mk(1, 32'h44, 0, 32'h00, 0, 0, 0, 0, 0, 10, 4);
    vecs[16] = mk(1, 32'h40, 1, 32'h40, 0, 0, 1, 0, 0, 10, 4);
    vecs[17] = mk(1, 32'h40, 1, 32'h40, 1, 0, 1, 1, 0, 11, 4);
    vecs[18] = mk(1, 32'h40, 1, 32'h40, 0, 1, 0, 1, 1, 12, 5);
    vecs[19] = mk(1, 32'h40, 0, 32'h00, 0, 0, 1, 0, 0, 13, 6);
    vecs[20] = mk(0, 32'h40, 0, 32'h40, 0, 1, 0, 0, 0, 13, 6);
    vecs[21] = mk(1, 32'h40, 0, 32'h00, 0, 0, 1, 0, 0, 13, 6);
    vecs[22] = mk(0, 32'h00, 1, 32'h44, 0, 0, 0, 0, 0, 13, 6);
    vecs[23] = mk(0, 32'h00, 1, 32'h44, 0, 0, 0, 0, 0, 14, 6);
    vecs[24] = mk(1, 32'h44, 1, 32'h44, 0, 1, 0, 1, 1, 15, 6);
    vecs[25] = mk(1, 32'h44, 0, 32'h00, 0, 0, 0, 0, 0, 16, 7);

    // Reset with active inputs: outputs forced low, in-flight update discarded.
    drive_idle();
    rst = 1'b1;
    lookup_valid = 1'b1; lookup_pc = 32'h0000_1234;
    resolve_valid = 1'b1; resolve_pc = 32'h44; resolve_predict = 1'b0; resolve_taken = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_predict", predict, 0);
    check("rst_flush", flush, 0);
    check("rst_redirect", redirect_taken, 0);
    check("rst_branch_count", branch_count, 0);
    check("rst_mispredict_count", mispredict_count, 0);
    drive_idle();
    rst = 1'b0;
    lookup_valid = 1'b1; lookup_pc = 32'h44;
    #1 check("post_rst_predict_0x44", predict, 0);
    lookup_pc = 32'h0000_ABCC;
    #1 check("post_rst_predict_any", predict, 0);

    // Table-driven run through training, hysteresis, aliasing and collision.
    for (int i = 0; i < 26; i++) begin
      @(posedge clk);
      #1;
      lookup_valid    = vecs[i].lv;
      lookup_pc       = vecs[i].lpc;
      resolve_valid   = vecs[i].rv;
      resolve_pc      = vecs[i].rpc;
      resolve_predict = vecs[i].rp;
      resolve_taken   = vecs[i].rt;
      e.id = i; e.e_pred = vecs[i].e_pred; e.e_flush = vecs[i].e_flush;
      e.e_redir = vecs[i].e_redir; e.e_bc = vecs[i].e_bc; e.e_mc = vecs[i].e_mc;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("v%0d_predict", e.id), predict, e.e_pred);
      check($sformatf("v%0d_flush", e.id), flush, e.e_flush);
      check($sformatf("v%0d_redirect", e.id), redirect_taken, e.e_redir);
      check($sformatf("v%0d_branch_count", e.id), branch_count, e.e_bc);
      check($sformatf("v%0d_mispredict_count", e.id), mispredict_count, e.e_mc);
    end
    check("scoreboard_empty", sb.size(), 0);

    // Saturation: 65,540 mispredicted taken resolves of 0x40.
    @(posedge clk);
    #1;
    drive_idle();
    resolve_valid = 1'b1; resolve_pc = 32'h40; resolve_predict = 1'b0; resolve_taken = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    drive_idle();
    lookup_valid = 1'b1; lookup_pc = 32'h40;
    @(negedge clk);
    check("sat_branch_count", branch_count, 16'hFFFF);
    check("sat_mispredict_count", mispredict_count, 16'hFFFF);
    check("sat_predict_0x40", predict, 1);

    // Reset pulse between edges clears state immediately.
    #1 rst = 1'b1;
    #1 check("pulse_predict_during", predict, 0);
    #1 rst = 1'b0;
    #1;
    check("pulse_branch_count", branch_count, 0);
    check("pulse_mispredict_count", mispredict_count, 0);
    check("pulse_predict_after", predict, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Dynamic branch predictor feeding the ID/EX pipeline register and consuming its branch fields back in EX. In ID it looks up a table of 2-bit saturating counters indexed by branch PC and drives the prediction bit latched with the branch. In EX it takes the resolved outcome with the latched branch/prediction bits, updates the table, raises the flush for a misprediction and keeps saturating branch/mispredict statistics.

## Interface
Parameters:
- ENTRIES, 16, number of counters; power of two, 2..256
- IDX_LSB, 2, lowest PC bit used for the index; index = pc[IDX_LSB +: log2(ENTRIES)]

Ports:
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- lookup_valid_i  in  1  ID stage holds a branch instruction
- lookup_pc_i  in  32  PC of the ID-stage instruction
- predict_o  out  1  predicted taken; feeds ID/EX prediction input
- resolve_valid_i  in  1  EX stage holds a branch; driven by ID/EX branch output
- resolve_pc_i  in  32  PC of the EX-stage instruction; driven by ID/EX PC output
- resolve_predict_i  in  1  prediction carried with the branch; driven by ID/EX prediction output
- resolve_taken_i  in  1  actual outcome computed in EX
- flush_o  out  1  misprediction; flushes IF/ID and ID/EX this cycle
- redirect_taken_o  out  1  on flush: 1 = fetch branch target, 0 = fetch PC+4 of branch
- branch_count_o  out  16  resolved branches since reset, saturating
- mispredict_count_o  out  16  mispredictions since reset, saturating

## Operation
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction = counter bit 1.
- Lookup (combinational): predict_o = lookup_valid_i & table[idx(lookup_pc_i)][1]; 0 when lookup_valid_i = 0.
- Resolve (combinational): flush_o = resolve_valid_i & (resolve_predict_i != resolve_taken_i); redirect_taken_o = resolve_taken_i when flush_o = 1, else 0.
- Update (rising edge, resolve_valid_i = 1): entry idx(resolve_pc_i) +1 if taken, saturating at 11; -1 if not taken, saturating at 00. No update when resolve_valid_i = 0.
- The update uses the table state, not resolve_predict_i; an aliased entry that changed since lookup is still updated by one step.
- branch_count_o +1 per edge with resolve_valid_i = 1; mispredict_count_o +1 per edge with flush_o = 1; both hold at 16'hFFFF.
- Tag-free: PCs sharing index bits share one counter.

## Timing
- Reset (rst_i high, asynchronous): every entry 01, both counts 0; predict_o, flush_o, redirect_taken_o forced 0 while rst_i high regardless of inputs.
- Reset mid-operation: table and counts clear immediately, not at the next edge; an update in flight that cycle is discarded.
- Lookup and resolve have zero-cycle latency; table update visible to lookups the cycle after the edge.
- Same cycle, same index lookup and update: predict_o reflects pre-update value; no bypass.
- flush_o is valid in the same cycle as resolve_valid_i so ID/EX clears on that edge. The flushed ID-stage branch is never resolved; only branches reaching EX update state.
- Back-to-back resolves of one index apply cumulatively, one step per cycle.

## Test plan
- Reset: assert rst_i with lookup_valid_i = 1 at any PC -> predict_o = 0, both counts 0; release, lookup any PC -> predict_o = 0 (entry 01).
- Training: resolve PC 0x40, predict 0, taken 1 -> flush_o = 1, redirect_taken_o = 1, next cycle lookup 0x40 -> predict_o = 1 (entry 10); second taken resolve -> entry 11, counts = 2/1.
- Hysteresis: entry 0x40 at 11, four more taken -> stays 11; one not-taken -> predict_o still 1; second not-taken -> predict_o = 0.
- Aliasing (ENTRIES 16, IDX_LSB 2): train 0x40 to 11 -> lookup 0x80 predicts 1, lookup 0x44 predicts 0.
- Same-cycle collision: entry 0x40 at 01, lookup 0x40 while resolving 0x40 taken -> predict_o = 0 that cycle, 1 the next.
- Saturation/reset: 65,540 mispredicted resolves -> both counts hold 16'hFFFF; pulse rst_i between edges -> counts 0 and predict_o = 0 before the next clock edge.
